// File: rtl/hsi_accel_pkg.sv
// Shared types and register map for the hyperspectral band-reduction accelerator.
package hsi_accel_pkg;

  typedef enum logic [1:0] {
    OpSum   = 2'b00,
    OpMax   = 2'b01,
    OpMin   = 2'b10,
    OpSumsq = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  // Word-aligned register offsets (addr_i[1:0] masked before compare).
  localparam logic [7:0] OffCtrl   = 8'h00;
  localparam logic [7:0] OffNbands = 8'h04;
  localparam logic [7:0] OffData   = 8'h08;
  localparam logic [7:0] OffResult = 8'h0C;
  localparam logic [7:0] OffStatus = 8'h10;

  // CTRL bit positions.
  localparam int unsigned CtrlStart = 0;
  localparam int unsigned CtrlClear = 1;
  localparam int unsigned CtrlOpLsb = 2;
  localparam int unsigned CtrlIrqEn = 4;

  // STATUS bit positions.
  localparam int unsigned StatBusy     = 0;
  localparam int unsigned StatDone     = 1;
  localparam int unsigned StatOverflow = 2;
  localparam int unsigned StatFull     = 3;
  localparam int unsigned StatEmpty    = 4;
  localparam int unsigned StatCountLsb = 8;

endpackage

// File: rtl/hsi_sample_fifo.sv
// Sample FIFO: power-of-two depth, wrapping pointers, count range 0..DEPTH.
module hsi_sample_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];

  // A push into a full FIFO is only legal when a pop frees a slot in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy next-state; flush wins over everything.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
      if (do_push && !do_pop) cnt_d = cnt_q + (PW+1)'(1);
      if (do_pop && !do_push) cnt_d = cnt_q - (PW+1)'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/hsi_reduce_obi.sv
// OBI-attached per-pixel band reducer: SUM / MAX / MIN / SUMSQ over NBANDS samples.
module hsi_reduce_obi
  import hsi_accel_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  output logic          gnt_o,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          rvalid_o,
  output logic          irq_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_e        state_q, state_d;
  op_e           run_op_q, run_op_d, ctrl_op_q, ctrl_op_d;
  logic          irq_en_q, irq_en_d, ovf_q, ovf_d, rvalid_q, rvalid_d;
  logic [15:0]   nbands_q, nbands_d, need_q, need_d, cnt_q, cnt_d;
  logic [DW-1:0] acc_q, acc_d, result_q, result_d, rdata_q, rdata_d;

  logic [7:0]          off;
  logic                wr_en, rd_en, ctrl_wr, start, clr, data_wr;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic [SAMPLE_W-1:0] fifo_data;
  logic [15:0]         status_w;

  logic [2*SAMPLE_W-1:0] sq;
  logic [DW-1:0]         samp_ext, addend, acc_next;
  logic [DW:0]           sum;
  logic                  first;

  logic unused_bits;
  assign unused_bits = ^{addr_i, wdata_i};

  assign gnt_o    = req_i;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign irq_o    = (state_q == StDone) & irq_en_q;

  assign off     = addr_i[7:0] & 8'hFC;
  assign wr_en   = req_i & we_i;
  assign rd_en   = req_i & ~we_i;
  assign ctrl_wr = wr_en & (off == OffCtrl);
  assign start   = ctrl_wr & wdata_i[CtrlStart];
  assign clr     = ctrl_wr & wdata_i[CtrlClear];
  assign data_wr = wr_en & (off == OffData);

  assign fifo_pop  = (state_q == StRun) & ~fifo_empty & ~clr;
  assign fifo_push = data_wr & (~fifo_full | fifo_pop);

  hsi_sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clr),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (wdata_i[SAMPLE_W-1:0]),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Accumulator update for the sample at the FIFO head; SUM/SUMSQ saturate.
  always_comb begin
    sq       = {{SAMPLE_W{1'b0}}, fifo_data} * {{SAMPLE_W{1'b0}}, fifo_data};
    samp_ext = DW'(fifo_data);
    addend   = (run_op_q == OpSumsq) ? DW'(sq) : samp_ext;
    sum      = {1'b0, acc_q} + {1'b0, addend};
    first    = (cnt_q == '0);
    acc_next = acc_q;
    unique case (run_op_q)
      OpSum, OpSumsq: acc_next = sum[DW] ? '1 : sum[DW-1:0];
      OpMax:          acc_next = (first || samp_ext > acc_q) ? samp_ext : acc_q;
      OpMin:          acc_next = (first || samp_ext < acc_q) ? samp_ext : acc_q;
      default:        acc_next = acc_q;
    endcase
  end

  // STATUS word assembly.
  always_comb begin
    status_w                          = '0;
    status_w[StatBusy]                = (state_q == StRun);
    status_w[StatDone]                = (state_q == StDone);
    status_w[StatOverflow]            = ovf_q;
    status_w[StatFull]                = fifo_full;
    status_w[StatEmpty]               = fifo_empty;
    status_w[StatCountLsb +: 8]       = 8'(fifo_count);
  end

  // Register writes and FSM next-state; clear overrides start and the pipeline.
  always_comb begin
    state_d   = state_q;
    run_op_d  = run_op_q;
    ctrl_op_d = ctrl_op_q;
    irq_en_d  = irq_en_q;
    nbands_d  = nbands_q;
    need_d    = need_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    result_d  = result_q;
    ovf_d     = ovf_q;

    if (ctrl_wr) begin
      ctrl_op_d = op_e'(wdata_i[CtrlOpLsb +: 2]);
      irq_en_d  = wdata_i[CtrlIrqEn];
    end
    if (wr_en && off == OffNbands) nbands_d = wdata_i[15:0];
    if (data_wr && fifo_full && !fifo_pop) ovf_d = 1'b1;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          if (nbands_q == '0) begin
            state_d  = StDone;
            result_d = '0;
          end else begin
            state_d  = StRun;
            acc_d    = '0;
            cnt_d    = '0;
            need_d   = nbands_q;
            run_op_d = op_e'(wdata_i[CtrlOpLsb +: 2]);
          end
        end
      end
      StRun: begin
        if (fifo_pop) begin
          acc_d = acc_next;
          cnt_d = cnt_q + 16'd1;
          if (cnt_q + 16'd1 == need_q) begin
            result_d = acc_next;
            state_d  = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (clr) begin
      state_d  = StIdle;
      ovf_d    = 1'b0;
      result_d = '0;
    end
  end

  // One-cycle OBI response; writes and unmapped reads return zero.
  always_comb begin
    rvalid_d = req_i;
    rdata_d  = '0;
    if (rd_en) begin
      case (off)
        OffCtrl:   rdata_d = DW'({irq_en_q, ctrl_op_q, 2'b00});
        OffNbands: rdata_d = DW'(nbands_q);
        OffResult: rdata_d = result_q;
        OffStatus: rdata_d = DW'(status_w);
        default:   rdata_d = '0;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      run_op_q  <= OpSum;
      ctrl_op_q <= OpSum;
      irq_en_q  <= 1'b0;
      nbands_q  <= '0;
      need_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      run_op_q  <= run_op_d;
      ctrl_op_q <= ctrl_op_d;
      irq_en_q  <= irq_en_d;
      nbands_q  <= nbands_d;
      need_q    <= need_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: doc/hsi_reduce_obi.md
HSI_REDUCE_OBI -- requirements
Module: hsi_reduce_obi

Interface
REQ-001 SHALL have parameter AW, default 32: OBI address width.
REQ-002 SHALL have parameter DW, default 32: OBI data width, and result width.
REQ-003 SHALL have parameter SAMPLE_W, default 16: unsigned band-sample width, at most DW/2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8: sample FIFO entries, a power of two, at least 2.
REQ-005 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port req_i, input, 1: OBI request.
REQ-008 SHALL have port gnt_o, output, 1: OBI grant.
REQ-009 SHALL have port addr_i, input, AW: byte address; only addr_i[7:0] is decoded.
REQ-010 SHALL have port we_i, input, 1: write enable.
REQ-011 SHALL have port wdata_i, input, DW: write data.
REQ-012 SHALL have port rdata_o, output, DW: read data.
REQ-013 SHALL have port rvalid_o, output, 1: response valid.
REQ-014 SHALL have port irq_o, output, 1: level interrupt, equal to STATUS.done AND CTRL.irq_en.

Function
REQ-015 SHALL drive gnt_o = req_i combinationally.
REQ-016 SHALL assert rvalid_o for exactly one cycle, in the cycle after each granted read or write.
REQ-017 SHALL drive rdata_o in the rvalid_o cycle; unmapped offsets and write responses SHALL read 0.
REQ-018 SHALL implement the registers below; all are word-aligned, and addr_i[1:0] is ignored.
- 0x00 CTRL: [0] start (write-1 pulse, reads 0); [1] clear (write-1 pulse, reads 0); [3:2] op; [4] irq_en.
- op encoding: 00 SUM, 01 MAX, 10 MIN, 11 SUMSQ.
- 0x04 NBANDS: [15:0] samples per pixel, R/W.
- 0x08 DATA: a write pushes wdata_i[SAMPLE_W-1:0] into the FIFO; reads return 0.
- 0x0C RESULT: read-only.
- 0x10 STATUS: read-only; [0] busy, [1] done, [2] overflow, [3] fifo_full, [4] fifo_empty, [15:8] fifo count.
REQ-019 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-020 SHALL, in IDLE on start with NBANDS != 0: clear the accumulator and band counter, latch op, clear done, and enter RUN.
REQ-021 SHALL, on start with NBANDS == 0: go directly to DONE with RESULT = 0 and done = 1.
REQ-022 SHALL ignore start while in RUN.
REQ-023 SHALL treat start in DONE as a start from IDLE.
REQ-024 SHALL, in RUN, pop and process one sample per cycle whenever the FIFO is non-empty, and stall without change when it is empty.
REQ-025 SHALL compute the accumulator per op:
- SUM: acc += sample.
- SUMSQ: acc += sample*sample.
- MAX: the first sample loads acc, then acc = max(acc, sample).
- MIN: the first sample loads acc, then acc = min(acc, sample).
- SUM and SUMSQ are DW-bit unsigned and saturate at 2^DW-1.
REQ-026 SHALL, when the NBANDS-th sample is processed, register the final value into RESULT, set done, and enter DONE; RESULT is valid the cycle after the last pop.
REQ-027 SHALL drop a DATA write when the FIFO is full with no pop in that cycle, and set sticky overflow.
REQ-028 SHALL accept a DATA write when the FIFO is full and a pop occurs in the same cycle.
REQ-029 SHALL allow DATA pushes in any state; samples written before start are consumed after start.
REQ-030 SHALL, on clear in any state: flush the FIFO, return to IDLE, clear done and overflow, and zero RESULT; clear takes priority over a start written in the same word.
REQ-031 SHALL wrap the FIFO pointers modulo FIFO_DEPTH.
REQ-032 SHALL make the FIFO count range 0..FIFO_DEPTH.

Reset
REQ-033 SHALL, on reset assertion, asynchronously force: FSM to IDLE; all registers and FIFO pointers to 0; gnt_o follows req_i; rdata_o = 0, rvalid_o = 0, irq_o = 0.
REQ-034 SHALL discard any in-flight pixel and any pending response when reset is asserted mid-operation.

Structure
REQ-035 SHALL take the following from package hsi_accel_pkg: the op enum, the FSM state enum, the register offset constants and the STATUS bit positions.
REQ-036 SHALL implement the FIFO as sub-module hsi_sample_fifo with parameters WIDTH and DEPTH and ports push, pop, data, full, empty and count.

Verification
REQ-037 SHALL cover: NBANDS=4, op SUM, write 1,2,3,4, start -> RESULT=10, done=1, and with irq_en=1 irq_o=1.
REQ-038 SHALL cover: op MAX then op MIN, samples 7,0xFFFF,3 with NBANDS=3 -> RESULT=0xFFFF, then RESULT=3.
REQ-039 SHALL cover: FIFO_DEPTH=8, no start, 9 DATA writes -> fifo_full=1, overflow=1, count=8; after start with NBANDS=8, count reaches 0 and the FSM waits in DONE.
REQ-040 SHALL cover: op SUMSQ, SAMPLE_W=16, DW=32, two samples of 0xFFFF -> RESULT=0xFFFFFFFF (saturated).
REQ-041 SHALL cover: start with NBANDS=6, 3 samples, then clear -> busy=0, fifo_empty=1, RESULT=0; a new start with NBANDS=0 -> done=1, RESULT=0.
REQ-042 SHALL cover: rst_ni pulsed low mid-RUN -> all outputs 0 in the same cycle, and STATUS after reset reads 0x10 (fifo_empty only).
